// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch update controller and its in-flight FIFO.
package branch_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Entries carry a full 32-bit PC; narrower PC_W builds zero-extend into it.
  localparam int unsigned ENTRY_PC_W = 32;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0] pc;
    logic                  pred_take;
  } entry_t;

  localparam int unsigned ENTRY_W = ENTRY_PC_W + 1;

  localparam logic [ENTRY_PC_W-1:0] PC_INC = 32'd4;

endpackage

// File: rtl/branch_inflight_fifo.sv
// In-flight branch FIFO: head is combinational, clear has priority over push/pop.
module branch_inflight_fifo
  import branch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  entry_t wdata_i,
  input  logic   pop_i,
  input  logic   clr_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_update_ctrl.sv
// Branch predictor training / redirect / flush sequencer between IF and EX.
// Optional statistics counters enabled with `define BRANCH_STATS_EN.
module branch_update_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_branch_valid,
  input  logic [PC_W-1:0] if_branch_pc,
  input  logic            if_pred_take,
  input  logic            ex_resolve_valid,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  output logic            if_stall,
  output logic            pc_jmp_feedback,
  output logic            pc_jmp_take,
  output logic [PC_W-1:0] pc_stash_base,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     resolved_count,
  output logic [31:0]     mispredict_count
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  state_e            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  entry_t            head, wentry;
  logic              full, empty, run, push, pop, mispredict;
  logic [PC_W-1:0]   head_pc;
  logic              fb_q, take_q, redir_q;
  logic [PC_W-1:0]   stash_q, redir_pc_q;

  assign run            = (state_q == ST_RUN);
  assign head_pc        = PC_W'(head.pc);
  assign wentry.pc      = ENTRY_PC_W'(if_branch_pc);
  assign wentry.pred_take = if_pred_take;

  branch_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .clr_i   (mispredict),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    push       = run && if_branch_valid && !full;
    pop        = run && ex_resolve_valid && !empty;
    mispredict = pop && (head.pred_take != ex_taken);
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) state_d = ST_RUN;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Training and redirect registers: one cycle behind the resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_q       <= 1'b0;
      take_q     <= 1'b0;
      stash_q    <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      fb_q    <= pop;
      redir_q <= mispredict;
      if (pop) begin
        take_q  <= ex_taken;
        stash_q <= head_pc;
      end
      if (mispredict)
        redir_pc_q <= ex_taken ? ex_target : head_pc + PC_W'(PC_INC);
    end
  end

  assign if_stall        = run && full;
  assign flush           = (state_q == ST_FLUSH);
  assign pc_jmp_feedback = fb_q;
  assign pc_jmp_take     = take_q;
  assign pc_stash_base   = stash_q;
  assign redirect_valid  = redir_q;
  assign redirect_pc     = redir_pc_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] res_cnt_q, mis_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      res_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (pop && (res_cnt_q != 32'hFFFF_FFFF))        res_cnt_q <= res_cnt_q + 1'b1;
      if (mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_q <= mis_cnt_q + 1'b1;
    end
  end

  assign resolved_count   = res_cnt_q;
  assign mispredict_count = mis_cnt_q;
`else
  assign resolved_count   = 32'd0;
  assign mispredict_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Self-checking bench for branch_update_ctrl: queue-based reference model plus directed literal checks.
module tb_branch_update_ctrl;

  localparam int DEPTH = 4;
  localparam int FC    = 2;
  localparam int PC_W  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_branch_valid;
  logic [PC_W-1:0] if_branch_pc;
  logic            if_pred_take;
  logic            ex_resolve_valid;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            if_stall;
  logic            pc_jmp_feedback;
  logic            pc_jmp_take;
  logic [PC_W-1:0] pc_stash_base;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic [31:0]     resolved_count;
  logic [31:0]     mispredict_count;

  always #5 clk = ~clk;

  branch_update_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC), .PC_W(PC_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_branch_valid  (if_branch_valid),
    .if_branch_pc     (if_branch_pc),
    .if_pred_take     (if_pred_take),
    .ex_resolve_valid (ex_resolve_valid),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .if_stall         (if_stall),
    .pc_jmp_feedback  (pc_jmp_feedback),
    .pc_jmp_take      (pc_jmp_take),
    .pc_stash_base    (pc_stash_base),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .resolved_count   (resolved_count),
    .mispredict_count (mispredict_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of outstanding branches and a flush-cycles-remaining counter.
  typedef struct packed {
    logic [31:0] pc;
    logic        pt;
  } ent_t;

  ent_t        q[$];
  int          flush_left;
  bit          model_live = 0;
  logic        e_fb, e_take, e_redir, e_flush, e_stall;
  logic [31:0] e_stash, e_rpc, e_rc, e_mc;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      flush_left = 0;
      {e_fb, e_take, e_redir, e_flush, e_stall} = '0;
      e_stash = 0; e_rpc = 0; e_rc = 0; e_mc = 0;
      model_live = 1;
    end else begin
      e_fb = 0;
      e_redir = 0;
      if (flush_left > 0) begin
        flush_left--;
      end else begin
        bit was_full, mis;
        ent_t h;
        was_full = (q.size() == DEPTH);
        mis = 0;
        if (ex_resolve_valid && q.size() > 0) begin
          h = q.pop_front();
          e_fb = 1;
          e_take = ex_taken;
          e_stash = h.pc;
          if (e_rc != 32'hFFFF_FFFF) e_rc++;
          if (h.pt != ex_taken) begin
            mis = 1;
            e_redir = 1;
            e_rpc = ex_taken ? ex_target : h.pc + 32'd4;
            q.delete();
            flush_left = FC;
            if (e_mc != 32'hFFFF_FFFF) e_mc++;
          end
        end
        if (if_branch_valid && !was_full && !mis) q.push_back('{pc: if_branch_pc, pt: if_pred_take});
      end
      e_flush = (flush_left > 0);
      e_stall = (flush_left == 0) && (q.size() == DEPTH);
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("m_stall", if_stall, e_stall);
      check("m_fb", pc_jmp_feedback, e_fb);
      check("m_take", pc_jmp_take, e_take);
      check("m_stash", pc_stash_base, e_stash);
      check("m_redir", redirect_valid, e_redir);
      check("m_rpc", redirect_pc, e_rpc);
      check("m_flush", flush, e_flush);
`ifdef BRANCH_STATS_EN
      check("m_rc", resolved_count, e_rc);
      check("m_mc", mispredict_count, e_mc);
`else
      check("m_rc", resolved_count, 32'd0);
      check("m_mc", mispredict_count, 32'd0);
`endif
    end
  end

  task automatic step(input logic bv, input logic [31:0] bpc, input logic pt,
                      input logic rv, input logic tk, input logic [31:0] tg);
    if_branch_valid  = bv;
    if_branch_pc     = bpc;
    if_pred_take     = pt;
    ex_resolve_valid = rv;
    ex_taken         = tk;
    ex_target        = tg;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    idle();
    check("rst_fb", pc_jmp_feedback, 0);
    check("rst_stash", pc_stash_base, 0);
    check("rst_redir", redirect_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_stall", if_stall, 0);

    // Correct prediction: training only.
    step(1, 32'h100, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h200);
    check("ok_fb", pc_jmp_feedback, 1);
    check("ok_take", pc_jmp_take, 1);
    check("ok_stash", pc_stash_base, 32'h100);
    check("ok_redir", redirect_valid, 0);
    check("ok_flush", flush, 0);
    idle();
    check("ok_fb_hold", pc_jmp_feedback, 0);
    check("ok_stash_hold", pc_stash_base, 32'h100);

    // Mispredict not-taken: redirect to pc+4 and two flush cycles.
    step(1, 32'h100, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h300);
    check("mp_redir", redirect_valid, 1);
    check("mp_rpc", redirect_pc, 32'h104);
    check("mp_flush1", flush, 1);
    check("mp_fb", pc_jmp_feedback, 1);
    step(1, 32'h500, 0, 1, 0, 0);
    check("mp_flush2", flush, 1);
    check("mp_redir_pulse", redirect_valid, 0);
    check("mp_fb_in_flush", pc_jmp_feedback, 0);
    idle();
    check("mp_flush_end", flush, 0);
    step(0, 0, 0, 1, 0, 0);
    check("mp_fifo_empty", pc_jmp_feedback, 0);

    // Mispredict with PC wrap at the top of the address space.
    step(1, 32'hFFFF_FFFC, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("wrap_rpc", redirect_pc, 32'h0);
    idle(); idle();
    step(1, 32'h40, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h1234);
    check("taken_rpc", redirect_pc, 32'h1234);
    idle(); idle();

    // Fill the FIFO, drop a branch while full, then free a slot.
    for (int i = 1; i <= 4; i++) step(1, 32'h10 * i, 0, 0, 0, 0);
    check("full_stall", if_stall, 1);
    step(1, 32'h50, 0, 1, 0, 0);
    check("full_pop_stash", pc_stash_base, 32'h10);
    check("full_unstall", if_stall, 0);
    step(1, 32'h60, 0, 0, 0, 0);
    check("full_restall", if_stall, 1);
    step(0, 0, 0, 1, 0, 0); check("drain1", pc_stash_base, 32'h20);
    step(0, 0, 0, 1, 0, 0); check("drain2", pc_stash_base, 32'h30);
    step(0, 0, 0, 1, 0, 0); check("drain3", pc_stash_base, 32'h40);
    step(0, 0, 0, 1, 0, 0); check("drain4", pc_stash_base, 32'h60);
    step(0, 0, 0, 1, 0, 0); check("drain_empty_fb", pc_jmp_feedback, 0);
    check("drain_empty_redir", redirect_valid, 0);

    // Simultaneous push and pop at count 2 keeps order and occupancy.
    step(1, 32'h70, 1, 0, 0, 0);
    step(1, 32'h80, 1, 0, 0, 0);
    step(1, 32'h90, 1, 1, 1, 32'h0);
    check("sim_stash0", pc_stash_base, 32'h70);
    step(0, 0, 0, 1, 1, 0); check("sim_stash1", pc_stash_base, 32'h80);
    step(0, 0, 0, 1, 1, 0); check("sim_stash2", pc_stash_base, 32'h90);
    step(0, 0, 0, 1, 1, 0); check("sim_empty", pc_jmp_feedback, 0);

    // Statistics, then reset during flush.
    reset = 1'b1; idle(); reset = 1'b0;
    step(1, 32'hA0, 1, 0, 0, 0);
    step(1, 32'hB0, 0, 1, 1, 32'h0);
    step(1, 32'hC0, 1, 1, 0, 32'h0);
    step(0, 0, 0, 1, 0, 32'h0);
`ifdef BRANCH_STATS_EN
    check("st_rc", resolved_count, 3);
    check("st_mc", mispredict_count, 1);
`endif
    check("st_flush", flush, 1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("rstf_flush", flush, 0);
    check("rstf_redir", redirect_valid, 0);
    check("rstf_rc", resolved_count, 0);
    check("rstf_mc", mispredict_count, 0);
    step(0, 0, 0, 1, 0, 0);
    check("rstf_empty", pc_jmp_feedback, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 249) == 0);
      step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1),
           $urandom_range(0, 9) < 4, $urandom_range(0, 3) != 0, $urandom);
    end
    reset = 1'b0;
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
